memory_manager: RTL and testbench



---
 rtl/memory_manager.sv | 169 ++++++++++++++++
 tb/tb_memory_manager.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_manager.sv
// rtl/memory_manager.sv - framebuffer SRAM arbiter/sequencer for video fetches and MCU reads/writes
// Video fetches win over MCU traffic; MCU writes win over MCU reads.
module memory_manager (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic [2:0]  currentState_o,
  input  logic [8:0]  videoXCoord_i,
  input  logic [7:0]  videoYCoord_i,
  output logic [7:0]  videoData_o,
  output logic        videoDataReady_o,
  input  logic [8:0]  memoryXCoord_i,
  input  logic [7:0]  memoryYCoord_i,
  input  logic        memoryReadRequest_i,
  input  logic        memoryWriteRequest_i,
  input  logic [7:0]  memoryWriteData_i,
  output logic [7:0]  memoryReadData_o,
  output logic        memoryReadComplete_o,
  output logic        memoryWriteComplete_o,
  output logic [16:0] ramAddress_o,
  inout  wire  [7:0]  ramData_io,
  output logic        ramOutputEnable_o,
  output logic        ramWriteEnable_o
);

  localparam logic [8:0] WIDTH  = 9'd320;
  localparam logic [7:0] HEIGHT = 8'd240;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    VREAD_ADDR  = 3'd1,
    VREAD_LATCH = 3'd2,
    WRITE_ADDR  = 3'd3,
    WRITE_PULSE = 3'd4,
    WRITE_END   = 3'd5,
    READ_ADDR   = 3'd6,
    READ_LATCH  = 3'd7
  } state_e;

  state_e      state_q;
  logic [16:0] addr_q;
  logic [7:0]  wdata_q;
  logic        in_range_q;
  logic [8:0]  last_x_q;
  logic [7:0]  last_y_q;
  logic        mcu_done_q;
  logic [7:0]  video_data_q;
  logic        video_ready_q;
  logic [7:0]  read_data_q;
  logic        read_complete_q;
  logic        write_complete_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        drive_q;

  logic [16:0] video_addr_d;
  logic [16:0] mcu_addr_d;
  logic        video_in_range_d;
  logic        mcu_in_range_d;
  logic        video_pending_d;

  // y*320 as (y<<8)+(y<<6) keeps the address path to adders only.
  always_comb begin
    video_addr_d     = ({9'd0, videoYCoord_i} << 8) + ({9'd0, videoYCoord_i} << 6)
                     + {8'd0, videoXCoord_i};
    mcu_addr_d       = ({9'd0, memoryYCoord_i} << 8) + ({9'd0, memoryYCoord_i} << 6)
                     + {8'd0, memoryXCoord_i};
    video_in_range_d = (videoXCoord_i < WIDTH) && (videoYCoord_i < HEIGHT);
    mcu_in_range_d   = (memoryXCoord_i < WIDTH) && (memoryYCoord_i < HEIGHT);
    video_pending_d  = (videoXCoord_i != last_x_q) || (videoYCoord_i != last_y_q);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      in_range_q       <= 1'b0;
      last_x_q         <= 9'd511;
      last_y_q         <= 8'd255;
      mcu_done_q       <= 1'b0;
      video_data_q     <= '0;
      video_ready_q    <= 1'b0;
      read_data_q      <= '0;
      read_complete_q  <= 1'b0;
      write_complete_q <= 1'b0;
      oe_n_q           <= 1'b1;
      we_n_q           <= 1'b1;
      drive_q          <= 1'b0;
    end else begin
      video_ready_q    <= 1'b0;
      read_complete_q  <= 1'b0;
      write_complete_q <= 1'b0;
      // Re-arm clears first so a completion on the same edge still sets the flag.
      if (!memoryReadRequest_i && !memoryWriteRequest_i) begin
        mcu_done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (video_pending_d) begin
            state_q    <= VREAD_ADDR;
            last_x_q   <= videoXCoord_i;
            last_y_q   <= videoYCoord_i;
            addr_q     <= video_addr_d;
            in_range_q <= video_in_range_d;
            oe_n_q     <= 1'b0;
          end else if (memoryWriteRequest_i && !mcu_done_q) begin
            state_q    <= WRITE_ADDR;
            addr_q     <= mcu_addr_d;
            wdata_q    <= memoryWriteData_i;
            in_range_q <= mcu_in_range_d;
            drive_q    <= 1'b1;
          end else if (memoryReadRequest_i && !mcu_done_q) begin
            state_q    <= READ_ADDR;
            addr_q     <= mcu_addr_d;
            in_range_q <= mcu_in_range_d;
            oe_n_q     <= 1'b0;
          end
        end
        VREAD_ADDR: state_q <= VREAD_LATCH;
        VREAD_LATCH: begin
          state_q       <= IDLE;
          video_data_q  <= in_range_q ? ramData_io : 8'd0;
          video_ready_q <= 1'b1;
          oe_n_q        <= 1'b1;
        end
        WRITE_ADDR: begin
          state_q <= WRITE_PULSE;
          we_n_q  <= !in_range_q;
        end
        WRITE_PULSE: begin
          state_q <= WRITE_END;
          we_n_q  <= 1'b1;
        end
        WRITE_END: begin
          state_q          <= IDLE;
          drive_q          <= 1'b0;
          write_complete_q <= 1'b1;
          mcu_done_q       <= 1'b1;
        end
        READ_ADDR: state_q <= READ_LATCH;
        READ_LATCH: begin
          state_q         <= IDLE;
          read_data_q     <= in_range_q ? ramData_io : 8'd0;
          read_complete_q <= 1'b1;
          mcu_done_q      <= 1'b1;
          oe_n_q          <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign ramData_io            = drive_q ? wdata_q : 8'bz;
  assign currentState_o        = state_q;
  assign ramAddress_o          = addr_q;
  assign ramOutputEnable_o     = oe_n_q;
  assign ramWriteEnable_o      = we_n_q;
  assign videoData_o           = video_data_q;
  assign videoDataReady_o      = video_ready_q;
  assign memoryReadData_o      = read_data_q;
  assign memoryReadComplete_o  = read_complete_q;
  assign memoryWriteComplete_o = write_complete_q;

endmodule

// File: tb/tb_memory_manager.sv
// tb/tb_memory_manager.sv - directed bench for memory_manager with a behavioural async SRAM
module tb_memory_manager;

  logic        clock;
  logic        reset;
  logic [2:0]  state;
  logic [8:0]  vx;
  logic [7:0]  vy;
  logic [7:0]  vdata;
  logic        vready;
  logic [8:0]  mx;
  logic [7:0]  my;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rd_done;
  logic        wr_done;
  logic [16:0] addr;
  wire  [7:0]  ram_data;
  logic        oe_n;
  logic        we_n;

  logic [7:0]  mem [0:131071];

  int n_cmp = 0;
  int n_err = 0;
  int cnt_a;
  int cnt_b;
  int at_a;
  int at_b;
  logic [7:0] cap;

  memory_manager dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .currentState_o       (state),
    .videoXCoord_i        (vx),
    .videoYCoord_i        (vy),
    .videoData_o          (vdata),
    .videoDataReady_o     (vready),
    .memoryXCoord_i       (mx),
    .memoryYCoord_i       (my),
    .memoryReadRequest_i  (rd_req),
    .memoryWriteRequest_i (wr_req),
    .memoryWriteData_i    (wdata),
    .memoryReadData_o     (rdata),
    .memoryReadComplete_o (rd_done),
    .memoryWriteComplete_o(wr_done),
    .ramAddress_o         (addr),
    .ramData_io           (ram_data),
    .ramOutputEnable_o    (oe_n),
    .ramWriteEnable_o     (we_n)
  );

  assign ram_data = oe_n ? 8'bz : mem[addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!we_n) mem[addr] = ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset) chk("oe_we_exclusive", 32'(oe_n | we_n), 32'd1);
  end

  initial begin
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    vx = 9'd511; vy = 8'd255; mx = '0; my = '0; wdata = '0;
    mem[651] = 8'h5C; mem[652] = 8'h9E; mem[76799] = 8'hA5;
    repeat (2) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_oe", 32'(oe_n), 32'd1);
    chk("rst_we", 32'(we_n), 32'd1);
    chk("rst_vdata", 32'(vdata), 32'd0);
    chk("rst_vready", 32'(vready), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_completes", 32'({rd_done, wr_done}), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_after_rst", 32'(state), 32'd0);

    // In-range write (10,2) -> 650
    mx = 9'd10; my = 8'd2; wdata = 8'd3; wr_req = 1'b1;
    tick();
    chk("w_addr_state", 32'(state), 32'd3);
    chk("w_addr", 32'(addr), 32'd650);
    chk("w_addr_we", 32'(we_n), 32'd1);
    chk("w_addr_bus", 32'(ram_data), 32'd3);
    tick();
    chk("w_pulse_state", 32'(state), 32'd4);
    chk("w_pulse_we", 32'(we_n), 32'd0);
    chk("w_pulse_bus", 32'(ram_data), 32'd3);
    tick();
    chk("w_end_state", 32'(state), 32'd5);
    chk("w_end_we", 32'(we_n), 32'd1);
    tick();
    chk("w_done_state", 32'(state), 32'd0);
    chk("w_done_pulse", 32'(wr_done), 32'd1);
    tick();
    chk("w_done_one_cycle", 32'(wr_done), 32'd0);
    tick();
    chk("w_no_repeat", 32'(state), 32'd0);
    wr_req = 1'b0;
    tick();
    chk("w_mem650", 32'(mem[650]), 32'd3);

    // Out-of-range write: no WE strobe, one completion
    mx = 9'd511; my = 8'd2; wdata = 8'hFF; wr_req = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!we_n) cnt_a++;
      if (wr_done) cnt_b++;
    end
    chk("oor_we_low_cycles", 32'(cnt_a), 32'd0);
    chk("oor_complete_count", 32'(cnt_b), 32'd1);
    wr_req = 1'b0;
    tick();

    // Reset asserted during WRITE_PULSE
    mx = 9'd5; my = 8'd1; wdata = 8'h77; wr_req = 1'b1;
    tick();
    tick();
    chk("rw_pulse_state", 32'(state), 32'd4);
    chk("rw_pulse_we", 32'(we_n), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rw_we_released", 32'(we_n), 32'd1);
    chk("rw_state", 32'(state), 32'd0);
    chk("rw_oe", 32'(oe_n), 32'd1);
    wr_req = 1'b0;
    cnt_b = 0;
    tick();
    if (wr_done) cnt_b++;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_done) cnt_b++;
    end
    chk("rw_no_complete", 32'(cnt_b), 32'd0);

    // Video fetch of (10,2)
    vx = 9'd10; vy = 8'd2;
    tick();
    chk("v_addr_state", 32'(state), 32'd1);
    chk("v_addr", 32'(addr), 32'd650);
    chk("v_addr_oe", 32'(oe_n), 32'd0);
    tick();
    chk("v_latch_state", 32'(state), 32'd2);
    chk("v_latch_oe", 32'(oe_n), 32'd0);
    tick();
    chk("v_ready", 32'(vready), 32'd1);
    chk("v_data", 32'(vdata), 32'd3);
    chk("v_oe_off", 32'(oe_n), 32'd1);
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vready || state != 3'd0) cnt_a++;
    end
    chk("v_no_refetch", 32'(cnt_a), 32'd0);

    // Video change and write request together: video first
    vx = 9'd11; vy = 8'd2; mx = 9'd20; my = 8'd0; wdata = 8'h44; wr_req = 1'b1;
    tick();
    chk("cv_video_first", 32'(state), 32'd1);
    at_a = 0; at_b = 0; cap = '0;
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (vready && at_a == 0) begin at_a = i; cap = vdata; end
      if (wr_done && at_b == 0) at_b = i;
    end
    chk("cv_ready_cycle", 32'(at_a), 32'd3);
    chk("cv_vdata", 32'(cap), 32'h5C);
    chk("cv_wdone_cycle", 32'(at_b), 32'd7);
    wr_req = 1'b0;
    tick();
    chk("cv_mem20", 32'(mem[20]), 32'h44);

    // Video change just after a write started: worst-case latency
    mx = 9'd21; my = 8'd0; wdata = 8'h01; wr_req = 1'b1;
    tick();
    chk("wc_write_started", 32'(state), 32'd3);
    vx = 9'd12; vy = 8'd2;
    at_a = 0; cap = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (vready && at_a == 0) begin at_a = i; cap = vdata; end
    end
    chk("wc_ready_cycle", 32'(at_a), 32'd6);
    chk("wc_vdata", 32'(cap), 32'h9E);
    wr_req = 1'b0;
    tick();

    // Write and read together at (319,239): write first, read after re-arm
    mx = 9'd319; my = 8'd239; wdata = 8'h11; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("wr_write_first", 32'(state), 32'd3);
    chk("wr_addr", 32'(addr), 32'd76799);
    at_b = 0;
    for (int i = 1; i <= 6 && at_b == 0; i++) begin
      tick();
      if (wr_done) at_b = i;
    end
    chk("wr_wdone_cycle", 32'(at_b), 32'd3);
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    chk("wr_rearm_idle", 32'(state), 32'd0);
    rd_req = 1'b1;
    tick();
    chk("r_addr_state", 32'(state), 32'd6);
    chk("r_addr", 32'(addr), 32'd76799);
    chk("r_addr_oe", 32'(oe_n), 32'd0);
    tick();
    chk("r_latch_state", 32'(state), 32'd7);
    tick();
    chk("r_done_pulse", 32'(rd_done), 32'd1);
    chk("r_data", 32'(rdata), 32'h11);
    chk("r_done_state", 32'(state), 32'd0);
    tick();
    chk("r_done_one_cycle", 32'(rd_done), 32'd0);
    rd_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
